cache_ctrl: RTL and testbench

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_ctrl.sv | 156 +++++++++++++++
 tb/tb_cache_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// Cache controller: compare / writeback / fill sequencing with a PLRU update
// on every completed request and a saturating miss counter.
module cache_ctrl #(
  parameter  int unsigned WAYS = 4,
  parameter  int unsigned SETS = 16,
  localparam int unsigned SW   = $clog2(SETS)
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            ufp_req,
  input  logic            ufp_we,
  input  logic [SW-1:0]   ufp_set,
  output logic            ufp_resp,

  input  logic [WAYS-1:0] hit_vector,
  input  logic [WAYS-1:0] valid_vector,
  input  logic [WAYS-1:0] dirty_vector,
  input  logic [WAYS-1:0] evict_candidate,

  output logic            plru_web,
  output logic [SW-1:0]   plru_set,
  output logic [WAYS-1:0] plru_hit_vector,

  output logic            data_we,
  output logic [WAYS-1:0] data_way,
  output logic            fill_we,
  output logic [WAYS-1:0] fill_way,
  output logic            dirty_set,
  output logic            dirty_clr,

  output logic            dfp_read,
  output logic            dfp_write,
  input  logic            dfp_resp,
  output logic [WAYS-1:0] wb_way,
  output logic [15:0]     miss_count
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COMPARE   = 2'd1,
    S_WRITEBACK = 2'd2,
    S_FILL      = 2'd3
  } state_t;

  localparam logic [15:0] MISS_MAX = 16'hFFFF;

  state_t          r_state;
  logic [SW-1:0]   r_set;
  logic            r_we;
  logic [WAYS-1:0] r_victim;
  logic [15:0]     r_miss_count;

  logic            w_hit;
  logic [WAYS-1:0] w_invalid;
  logic [WAYS-1:0] w_lowest_invalid;
  logic [WAYS-1:0] w_victim;
  logic            w_victim_dirty;

  // Victim choice: an empty way wins (lowest index first), else the PLRU pick.
  assign w_hit            = |hit_vector;
  assign w_invalid        = ~valid_vector;
  assign w_lowest_invalid = w_invalid & (~w_invalid + WAYS'(1));
  assign w_victim         = (|w_invalid) ? w_lowest_invalid : evict_candidate;
  assign w_victim_dirty   = |(w_victim & valid_vector & dirty_vector);

  // State register, request latch, victim latch and saturating miss counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_set        <= '0;
      r_we         <= 1'b0;
      r_victim     <= '0;
      r_miss_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ufp_req) begin
            r_set   <= ufp_set;
            r_we    <= ufp_we;
            r_state <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          if (w_hit) begin
            r_state <= S_IDLE;
          end else begin
            r_victim <= w_victim;
            if (r_miss_count != MISS_MAX) begin
              r_miss_count <= r_miss_count + 16'd1;
            end
            r_state <= w_victim_dirty ? S_WRITEBACK : S_FILL;
          end
        end
        S_WRITEBACK: begin
          if (dfp_resp) begin
            r_state <= S_FILL;
          end
        end
        S_FILL: begin
          if (dfp_resp) begin
            r_state <= S_COMPARE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobe decode: state-held memory requests, same-cycle hit/fill strobes.
  always_comb begin
    ufp_resp        = 1'b0;
    plru_web        = 1'b1;
    plru_hit_vector = '0;
    data_we         = 1'b0;
    data_way        = '0;
    fill_we         = 1'b0;
    fill_way        = '0;
    dirty_set       = 1'b0;
    dirty_clr       = 1'b0;
    dfp_read        = 1'b0;
    dfp_write       = 1'b0;
    wb_way          = '0;
    case (r_state)
      S_COMPARE: begin
        if (w_hit) begin
          ufp_resp        = 1'b1;
          plru_web        = 1'b0;
          plru_hit_vector = hit_vector;
          if (r_we) begin
            data_we   = 1'b1;
            dirty_set = 1'b1;
            data_way  = hit_vector;
          end
        end
      end
      S_WRITEBACK: begin
        dfp_write = 1'b1;
        wb_way    = r_victim;
      end
      S_FILL: begin
        dfp_read = 1'b1;
        if (dfp_resp) begin
          fill_we   = 1'b1;
          dirty_clr = 1'b1;
          fill_way  = r_victim;
        end
      end
      default: ;
    endcase
  end

  assign plru_set   = r_set;
  assign miss_count = r_miss_count;

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: hit table plus hand sequences for misses,
// writeback, reset during fill and miss-counter saturation.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ufp_req, ufp_we;
  logic [3:0]  ufp_set;
  logic        ufp_resp;
  logic [3:0]  hit_vector, valid_vector, dirty_vector, evict_candidate;
  logic        plru_web;
  logic [3:0]  plru_set, plru_hit_vector;
  logic        data_we, fill_we, dirty_set, dirty_clr;
  logic [3:0]  data_way, fill_way, wb_way;
  logic        dfp_read, dfp_write, dfp_resp;
  logic [15:0] miss_count;

  int n_checks = 0;
  int n_fail   = 0;

  cache_ctrl #(.WAYS(4), .SETS(16)) dut (
    .clk(clk), .rst(rst),
    .ufp_req(ufp_req), .ufp_we(ufp_we), .ufp_set(ufp_set), .ufp_resp(ufp_resp),
    .hit_vector(hit_vector), .valid_vector(valid_vector),
    .dirty_vector(dirty_vector), .evict_candidate(evict_candidate),
    .plru_web(plru_web), .plru_set(plru_set), .plru_hit_vector(plru_hit_vector),
    .data_we(data_we), .data_way(data_way), .fill_we(fill_we), .fill_way(fill_way),
    .dirty_set(dirty_set), .dirty_clr(dirty_clr),
    .dfp_read(dfp_read), .dfp_write(dfp_write), .dfp_resp(dfp_resp),
    .wb_way(wb_way), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [3:0] set;
    logic [3:0] hit;
    logic       exp_data_we;
    logic [3:0] exp_data_way;
  } hit_vec_t;

  hit_vec_t tbl [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance one full cycle; inputs change and outputs are sampled at negedge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a request in IDLE; returns with the DUT in COMPARE at a negedge.
  task automatic issue(input logic we, input logic [3:0] set);
    ufp_req = 1'b1;
    ufp_we  = we;
    ufp_set = set;
    cyc();
    ufp_req = 1'b0;
    ufp_we  = 1'b0;
    ufp_set = 4'hA;
  endtask

  initial begin
    tbl[0] = '{we: 1'b0, set: 4'd3,  hit: 4'b0100, exp_data_we: 1'b0, exp_data_way: 4'b0000};
    tbl[1] = '{we: 1'b1, set: 4'd5,  hit: 4'b0001, exp_data_we: 1'b1, exp_data_way: 4'b0001};
    tbl[2] = '{we: 1'b1, set: 4'd15, hit: 4'b1000, exp_data_we: 1'b1, exp_data_way: 4'b1000};
    tbl[3] = '{we: 1'b0, set: 4'd0,  hit: 4'b0010, exp_data_we: 1'b0, exp_data_way: 4'b0000};

    rst = 1'b1;
    ufp_req = 1'b0; ufp_we = 1'b0; ufp_set = 4'd0;
    hit_vector = 4'b0000; valid_vector = 4'b1111; dirty_vector = 4'b0000;
    evict_candidate = 4'b0001; dfp_resp = 1'b0;

    // Reset state
    @(negedge clk);
    #2;
    chk("rst_plru_web", 32'(plru_web), 32'd1);
    chk("rst_ufp_resp", 32'(ufp_resp), 32'd0);
    chk("rst_miss_count", 32'(miss_count), 32'd0);
    chk("rst_plru_set", 32'(plru_set), 32'd0);
    chk("rst_dfp_rw", 32'({dfp_read, dfp_write}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // Stray memory response in IDLE does nothing
    dfp_resp = 1'b1;
    cyc();
    dfp_resp = 1'b0;
    #2;
    chk("idle_dfp_resp_ignored", 32'({ufp_resp, dfp_read, dfp_write, fill_we}), 32'd0);
    @(negedge clk);

    // Hit table
    for (int i = 0; i < 4; i++) begin
      issue(tbl[i].we, tbl[i].set);
      hit_vector = tbl[i].hit;
      #2;
      chk($sformatf("hit%0d_resp", i), 32'(ufp_resp), 32'd1);
      chk($sformatf("hit%0d_plru_web", i), 32'(plru_web), 32'd0);
      chk($sformatf("hit%0d_plru_hit", i), 32'(plru_hit_vector), 32'(tbl[i].hit));
      chk($sformatf("hit%0d_plru_set", i), 32'(plru_set), 32'(tbl[i].set));
      chk($sformatf("hit%0d_data_we", i), 32'({data_we, dirty_set}), 32'({tbl[i].exp_data_we, tbl[i].exp_data_we}));
      chk($sformatf("hit%0d_data_way", i), 32'(data_way), 32'(tbl[i].exp_data_way));
      @(negedge clk);
      #2;
      chk($sformatf("hit%0d_single_resp", i), 32'({ufp_resp, plru_web}), 32'b01);
      hit_vector = 4'b0000;
      @(negedge clk);
    end
    chk("hits_no_miss", 32'(miss_count), 32'd0);

    // Clean miss, invalid way 2 chosen, memory latency 2
    valid_vector = 4'b1011; dirty_vector = 4'b0000; evict_candidate = 4'b0001;
    issue(1'b0, 4'd7);
    #2;
    chk("cmiss_no_resp", 32'({ufp_resp, plru_web}), 32'b01);
    @(negedge clk);
    #2;
    chk("cmiss_fill_read", 32'({dfp_read, dfp_write}), 32'b10);
    chk("cmiss_count", 32'(miss_count), 32'd1);
    @(negedge clk);
    #2;
    chk("cmiss_read_held", 32'({dfp_read, fill_we}), 32'b10);
    @(negedge clk);
    dfp_resp = 1'b1;
    #2;
    chk("cmiss_fill_we", 32'({fill_we, dirty_clr}), 32'b11);
    chk("cmiss_fill_way", 32'(fill_way), 32'b0100);
    @(negedge clk);
    dfp_resp = 1'b0;
    hit_vector = 4'b0100;
    #2;
    chk("cmiss_read_drop", 32'(dfp_read), 32'd0);
    chk("cmiss_recmp_resp", 32'({ufp_resp, plru_web}), 32'b10);
    chk("cmiss_recmp_plru", 32'({plru_set, plru_hit_vector}), 32'h74);
    @(negedge clk);
    hit_vector = 4'b0000;
    #2;
    chk("cmiss_idle", 32'({ufp_resp, miss_count}), 32'd1);
    @(negedge clk);

    // Dirty miss: writeback of way 3, then fill, then store hit
    valid_vector = 4'b1111; dirty_vector = 4'b1000; evict_candidate = 4'b1000;
    issue(1'b1, 4'd2);
    #2;
    chk("dmiss_no_resp", 32'({ufp_resp, data_we}), 32'd0);
    @(negedge clk);
    #2;
    chk("dmiss_write", 32'({dfp_write, dfp_read}), 32'b10);
    chk("dmiss_wb_way", 32'(wb_way), 32'b1000);
    chk("dmiss_count", 32'(miss_count), 32'd2);
    @(negedge clk);
    dfp_resp = 1'b1;
    #2;
    chk("dmiss_wb_no_fill", 32'({dfp_write, fill_we}), 32'b10);
    @(negedge clk);
    dfp_resp = 1'b0;
    #2;
    chk("dmiss_read", 32'({dfp_read, dfp_write}), 32'b10);
    @(negedge clk);
    dfp_resp = 1'b1;
    #2;
    chk("dmiss_fill", 32'({fill_we, dirty_clr, fill_way}), 32'b11_1000);
    @(negedge clk);
    dfp_resp = 1'b0;
    hit_vector = 4'b1000;
    #2;
    chk("dmiss_recmp", 32'({ufp_resp, plru_web, data_we, dirty_set}), 32'b1011);
    chk("dmiss_data_way", 32'(data_way), 32'b1000);
    @(negedge clk);
    hit_vector = 4'b0000;
    #2;
    chk("dmiss_one_resp", 32'(ufp_resp), 32'd0);
    @(negedge clk);

    // All valid, PLRU victim clean: straight to fill
    valid_vector = 4'b1111; dirty_vector = 4'b0001; evict_candidate = 4'b0010;
    issue(1'b0, 4'd9);
    @(negedge clk);
    #2;
    chk("cvict_fill", 32'({dfp_read, dfp_write}), 32'b10);
    dfp_resp = 1'b1;
    #2;
    chk("cvict_fill_way", 32'(fill_way), 32'b0010);

    // Reset during fill
    #1;
    rst = 1'b1;
    #1;
    chk("rfill_read_drop", 32'({dfp_read, fill_we, ufp_resp}), 32'd0);
    chk("rfill_count", 32'(miss_count), 32'd0);
    chk("rfill_plru_set", 32'({plru_web, plru_set}), 32'h10);
    @(negedge clk);
    dfp_resp = 1'b0;
    rst = 1'b0;
    cyc();
    #2;
    chk("rfill_idle", 32'({dfp_read, dfp_write, fill_we, ufp_resp}), 32'd0);
    @(negedge clk);

    // Saturation: preset near the top, then two misses
    force dut.r_miss_count = 16'hFFFE;
    cyc();
    release dut.r_miss_count;
    cyc();
    chk("sat_preset", 32'(miss_count), 32'hFFFE);
    valid_vector = 4'b1111; dirty_vector = 4'b0000; evict_candidate = 4'b0100;
    issue(1'b0, 4'd1);
    @(negedge clk);
    chk("sat_reach_max", 32'(miss_count), 32'hFFFF);
    dfp_resp = 1'b1;
    @(negedge clk);
    dfp_resp = 1'b0;
    @(negedge clk);
    chk("sat_hold", 32'(miss_count), 32'hFFFF);
    dfp_resp = 1'b1;
    @(negedge clk);
    dfp_resp = 1'b0;
    hit_vector = 4'b0100;
    #2;
    chk("sat_final_resp", 32'(ufp_resp), 32'd1);
    @(negedge clk);
    hit_vector = 4'b0000;
    chk("sat_final_count", 32'(miss_count), 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
